sys_array_3x3: RTL and testbench

- Weight-stationary systolic matrix-vector engine with 3 columns and a 6-deep reduction (K=6), split into two 3-row planes.
- Main plane (rows 0-2): activations from act_in_vec, weights from weight_in_vec.
- Cascade plane (rows 3-5): activations from act_inter, weights from weight_inter.
- Per input vector, emits a per-column partial sum after row 2 on accum_inter and the full 6-row sum on accum_out_vec.
- Every channel uses the busy/vld/data flex-channel handshake.

---
 rtl/sys_array_3x3_pkg.sv | 23 ++
 rtl/sys_array_pe.sv | 31 +++
 rtl/sys_array_3x3.sv | 204 ++++++++++++++++++++
 tb/tb_sys_array_3x3.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_3x3_pkg.sv
// Shared widths, signed data types and a multiply-extend helper for the
// 3x3-column, 6-deep weight-stationary matrix-vector engine.
package sys_array_3x3_pkg;

  localparam int SA_DW    = 8;   // activation / weight width
  localparam int SA_AW    = 32;  // accumulator / result width
  localparam int SA_ROWS  = 6;   // reduction depth (two planes of 3)
  localparam int SA_PLANE = 3;   // rows per plane
  localparam int SA_COLS  = 3;   // output columns

  typedef logic signed [SA_DW-1:0] sa_data_t;
  typedef logic signed [SA_AW-1:0] sa_acc_t;

  // Signed DWxDW product, sign-extended to the accumulator width.
  function automatic sa_acc_t sa_mul_ext(input sa_data_t a, input sa_data_t w);
    sa_acc_t ax;
    sa_acc_t wx;
    ax = sa_acc_t'(a);
    wx = sa_acc_t'(w);
    return ax * wx;
  endfunction

endpackage

// File: rtl/sys_array_pe.sv
// Processing element: holds one stationary weight and adds a*w into the
// partial sum travelling down its column.
module sys_array_pe
  import sys_array_3x3_pkg::*;
#(
  parameter int DW = SA_DW,
  parameter int AW = SA_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          w_ld_i,
  input  logic [DW-1:0] w_i,
  input  logic [DW-1:0] a_i,
  input  logic [AW-1:0] psum_i,
  output logic [AW-1:0] psum_o
);

  logic [DW-1:0] w_q;
  logic [AW-1:0] prod;

  // Stationary weight; only a matching load token overwrites it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       w_q <= '0;
    else if (w_ld_i) w_q <= w_i;
  end

  // Both operands are sign-extended to AW first, so the product wraps mod 2^AW.
  assign prod   = AW'($signed(a_i)) * AW'($signed(w_q));
  assign psum_o = psum_i + prod;

endmodule

// File: rtl/sys_array_3x3.sv
// Weight-stationary matrix-vector engine: 3 columns, 6-row reduction split
// into a main plane (rows 0-2) and a cascade plane (rows 3-5). Each vector
// produces a partial sum after row 2 and a full sum after row 5 per column.
module sys_array_3x3
  import sys_array_3x3_pkg::*;
#(
  parameter int DW       = SA_DW,
  parameter int AW       = SA_AW,
  parameter int NUM_VECS = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic          weight_in_vec_busy_0,
  output logic          weight_in_vec_busy_1,
  output logic          weight_in_vec_busy_2,
  input  logic          weight_in_vec_vld_0,
  input  logic          weight_in_vec_vld_1,
  input  logic          weight_in_vec_vld_2,
  input  logic [DW-1:0] weight_in_vec_data_0,
  input  logic [DW-1:0] weight_in_vec_data_1,
  input  logic [DW-1:0] weight_in_vec_data_2,
  output logic          weight_inter_busy_0,
  output logic          weight_inter_busy_1,
  output logic          weight_inter_busy_2,
  input  logic          weight_inter_vld_0,
  input  logic          weight_inter_vld_1,
  input  logic          weight_inter_vld_2,
  input  logic [DW-1:0] weight_inter_data_0,
  input  logic [DW-1:0] weight_inter_data_1,
  input  logic [DW-1:0] weight_inter_data_2,
  output logic          act_in_vec_busy_0,
  output logic          act_in_vec_busy_1,
  output logic          act_in_vec_busy_2,
  input  logic          act_in_vec_vld_0,
  input  logic          act_in_vec_vld_1,
  input  logic          act_in_vec_vld_2,
  input  logic [DW-1:0] act_in_vec_data_0,
  input  logic [DW-1:0] act_in_vec_data_1,
  input  logic [DW-1:0] act_in_vec_data_2,
  output logic          act_inter_busy_0,
  output logic          act_inter_busy_1,
  output logic          act_inter_busy_2,
  input  logic          act_inter_vld_0,
  input  logic          act_inter_vld_1,
  input  logic          act_inter_vld_2,
  input  logic [DW-1:0] act_inter_data_0,
  input  logic [DW-1:0] act_inter_data_1,
  input  logic [DW-1:0] act_inter_data_2,
  input  logic          accum_out_vec_busy_0,
  input  logic          accum_out_vec_busy_1,
  input  logic          accum_out_vec_busy_2,
  output logic          accum_out_vec_vld_0,
  output logic          accum_out_vec_vld_1,
  output logic          accum_out_vec_vld_2,
  output logic [AW-1:0] accum_out_vec_data_0,
  output logic [AW-1:0] accum_out_vec_data_1,
  output logic [AW-1:0] accum_out_vec_data_2,
  input  logic          accum_inter_busy_0,
  input  logic          accum_inter_busy_1,
  input  logic          accum_inter_busy_2,
  output logic          accum_inter_vld_0,
  output logic          accum_inter_vld_1,
  output logic          accum_inter_vld_2,
  output logic [AW-1:0] accum_inter_data_0,
  output logic [AW-1:0] accum_inter_data_1,
  output logic [AW-1:0] accum_inter_data_2
);

  localparam logic [7:0] VCNT_MAX = 8'(NUM_VECS);

  // Weight channels 0-2 feed main-plane columns, 3-5 cascade-plane columns.
  // Activation channels 0-2 feed rows 0-2, 3-5 feed rows 3-5.
  logic [5:0]                w_vld, w_busy, w_full, w_fire;
  logic [5:0][DW-1:0]        w_data;
  logic [5:0]                a_vld;
  logic [5:0][DW-1:0]        a_data;
  logic [2:0]                int_busy, out_busy;

  logic [5:0][1:0]           wcnt_q, wcnt_d;
  logic [7:0]                vcnt_q, vcnt_d;
  logic [2:0]                int_vld_q, int_vld_d, out_vld_q, out_vld_d;
  logic [2:0][AW-1:0]        int_data_q, out_data_q;
  logic [SA_ROWS-1:0][2:0][AW-1:0] psum;

  logic compute_en, act_fire, pending, release_w, act_busy;

  assign w_vld  = {weight_inter_vld_2, weight_inter_vld_1, weight_inter_vld_0,
                   weight_in_vec_vld_2, weight_in_vec_vld_1, weight_in_vec_vld_0};
  assign w_data = {weight_inter_data_2, weight_inter_data_1, weight_inter_data_0,
                   weight_in_vec_data_2, weight_in_vec_data_1, weight_in_vec_data_0};
  assign a_vld  = {act_inter_vld_2, act_inter_vld_1, act_inter_vld_0,
                   act_in_vec_vld_2, act_in_vec_vld_1, act_in_vec_vld_0};
  assign a_data = {act_inter_data_2, act_inter_data_1, act_inter_data_0,
                   act_in_vec_data_2, act_in_vec_data_1, act_in_vec_data_0};
  assign int_busy = {accum_inter_busy_2, accum_inter_busy_1, accum_inter_busy_0};
  assign out_busy = {accum_out_vec_busy_2, accum_out_vec_busy_1, accum_out_vec_busy_0};

  // A weight channel stops accepting once its three rows are loaded.
  for (genvar ch = 0; ch < 6; ch++) begin : g_wch
    assign w_full[ch] = (wcnt_q[ch] == 2'd3);
  end
  assign w_busy = {6{rst}} | w_full;
  assign w_fire = w_vld & ~w_busy;

  // One vector in flight at a time: compute waits until every result drained.
  assign pending    = |{int_vld_q, out_vld_q};
  assign compute_en = (&w_full) & ~pending;
  assign act_busy   = rst | ~compute_en;
  assign act_fire   = compute_en & (&a_vld);

  // Next-state for handshake valids, weight counters and the vector counter.
  always_comb begin
    wcnt_d    = wcnt_q;
    vcnt_d    = vcnt_q;
    int_vld_d = act_fire ? 3'b111 : (int_vld_q & int_busy);
    out_vld_d = act_fire ? 3'b111 : (out_vld_q & out_busy);
    // Release weights on the edge that drains the last result of the set,
    // so weight busy is already low in the following cycle.
    release_w = (vcnt_q == VCNT_MAX) && !(|{int_vld_d, out_vld_d});
    for (int ch = 0; ch < 6; ch++) begin
      if (release_w)       wcnt_d[ch] = 2'd0;
      else if (w_fire[ch]) wcnt_d[ch] = wcnt_q[ch] + 2'd1;
    end
    if (release_w)     vcnt_d = 8'd0;
    else if (act_fire) vcnt_d = vcnt_q + 8'd1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q    <= '0;
      vcnt_q    <= '0;
      int_vld_q <= '0;
      out_vld_q <= '0;
    end else begin
      wcnt_q    <= wcnt_d;
      vcnt_q    <= vcnt_d;
      int_vld_q <= int_vld_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Capture the row-2 and row-5 column sums when a vector is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_data_q <= '0;
      out_data_q <= '0;
    end else if (act_fire) begin
      for (int c = 0; c < 3; c++) begin
        int_data_q[c] <= psum[SA_PLANE-1][c];
        out_data_q[c] <= psum[SA_ROWS-1][c];
      end
    end
  end

  // 6x3 PE grid; partial sums flow down each column, row r uses act channel r.
  for (genvar r = 0; r < SA_ROWS; r++) begin : g_row
    for (genvar c = 0; c < SA_COLS; c++) begin : g_col
      localparam int CH = (r < SA_PLANE) ? c : SA_PLANE + c;
      localparam int K  = r % SA_PLANE;
      logic [AW-1:0] psum_in;
      if (r == 0) begin : g_top
        assign psum_in = '0;
      end else begin : g_chain
        assign psum_in = psum[r-1][c];
      end
      sys_array_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk_i  (clk),
        .rst_i  (rst),
        .w_ld_i (w_fire[CH] && (wcnt_q[CH] == 2'(K))),
        .w_i    (w_data[CH]),
        .a_i    (a_data[r]),
        .psum_i (psum_in),
        .psum_o (psum[r][c])
      );
    end
  end

  assign weight_in_vec_busy_0 = w_busy[0];
  assign weight_in_vec_busy_1 = w_busy[1];
  assign weight_in_vec_busy_2 = w_busy[2];
  assign weight_inter_busy_0  = w_busy[3];
  assign weight_inter_busy_1  = w_busy[4];
  assign weight_inter_busy_2  = w_busy[5];
  assign act_in_vec_busy_0    = act_busy;
  assign act_in_vec_busy_1    = act_busy;
  assign act_in_vec_busy_2    = act_busy;
  assign act_inter_busy_0     = act_busy;
  assign act_inter_busy_1     = act_busy;
  assign act_inter_busy_2     = act_busy;
  assign accum_inter_vld_0    = int_vld_q[0];
  assign accum_inter_vld_1    = int_vld_q[1];
  assign accum_inter_vld_2    = int_vld_q[2];
  assign accum_inter_data_0   = int_data_q[0];
  assign accum_inter_data_1   = int_data_q[1];
  assign accum_inter_data_2   = int_data_q[2];
  assign accum_out_vec_vld_0  = out_vld_q[0];
  assign accum_out_vec_vld_1  = out_vld_q[1];
  assign accum_out_vec_vld_2  = out_vld_q[2];
  assign accum_out_vec_data_0 = out_data_q[0];
  assign accum_out_vec_data_1 = out_data_q[1];
  assign accum_out_vec_data_2 = out_data_q[2];

endmodule

// File: tb/tb_sys_array_3x3.sv
// Bench for sys_array_3x3: directed scenarios plus a result scoreboard fed
// from a reference model of the loaded weights.
module tb_sys_array_3x3;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] wiv_vld, wit_vld, aiv_vld, ait_vld, out_busy, int_busy;
  logic [7:0] wiv_data[3], wit_data[3], aiv_data[3], ait_data[3];
  logic [2:0] wiv_busy, wit_busy, aiv_busy, ait_busy, out_vld, int_vld;
  logic [31:0] out_data[3], int_data[3];

  typedef struct packed {
    logic [2:0][31:0] p;
    logic [2:0][31:0] f;
  } exp_t;

  exp_t sbq[$];
  logic [2:0] got_p, got_f;
  int wm[6][3];
  int n_pass, n_total;

  always #5 clk = ~clk;

  sys_array_3x3 dut (
    .clk(clk), .rst(rst),
    .weight_in_vec_busy_0(wiv_busy[0]), .weight_in_vec_busy_1(wiv_busy[1]), .weight_in_vec_busy_2(wiv_busy[2]),
    .weight_in_vec_vld_0(wiv_vld[0]), .weight_in_vec_vld_1(wiv_vld[1]), .weight_in_vec_vld_2(wiv_vld[2]),
    .weight_in_vec_data_0(wiv_data[0]), .weight_in_vec_data_1(wiv_data[1]), .weight_in_vec_data_2(wiv_data[2]),
    .weight_inter_busy_0(wit_busy[0]), .weight_inter_busy_1(wit_busy[1]), .weight_inter_busy_2(wit_busy[2]),
    .weight_inter_vld_0(wit_vld[0]), .weight_inter_vld_1(wit_vld[1]), .weight_inter_vld_2(wit_vld[2]),
    .weight_inter_data_0(wit_data[0]), .weight_inter_data_1(wit_data[1]), .weight_inter_data_2(wit_data[2]),
    .act_in_vec_busy_0(aiv_busy[0]), .act_in_vec_busy_1(aiv_busy[1]), .act_in_vec_busy_2(aiv_busy[2]),
    .act_in_vec_vld_0(aiv_vld[0]), .act_in_vec_vld_1(aiv_vld[1]), .act_in_vec_vld_2(aiv_vld[2]),
    .act_in_vec_data_0(aiv_data[0]), .act_in_vec_data_1(aiv_data[1]), .act_in_vec_data_2(aiv_data[2]),
    .act_inter_busy_0(ait_busy[0]), .act_inter_busy_1(ait_busy[1]), .act_inter_busy_2(ait_busy[2]),
    .act_inter_vld_0(ait_vld[0]), .act_inter_vld_1(ait_vld[1]), .act_inter_vld_2(ait_vld[2]),
    .act_inter_data_0(ait_data[0]), .act_inter_data_1(ait_data[1]), .act_inter_data_2(ait_data[2]),
    .accum_out_vec_busy_0(out_busy[0]), .accum_out_vec_busy_1(out_busy[1]), .accum_out_vec_busy_2(out_busy[2]),
    .accum_out_vec_vld_0(out_vld[0]), .accum_out_vec_vld_1(out_vld[1]), .accum_out_vec_vld_2(out_vld[2]),
    .accum_out_vec_data_0(out_data[0]), .accum_out_vec_data_1(out_data[1]), .accum_out_vec_data_2(out_data[2]),
    .accum_inter_busy_0(int_busy[0]), .accum_inter_busy_1(int_busy[1]), .accum_inter_busy_2(int_busy[2]),
    .accum_inter_vld_0(int_vld[0]), .accum_inter_vld_1(int_vld[1]), .accum_inter_vld_2(int_vld[2]),
    .accum_inter_data_0(int_data[0]), .accum_inter_data_1(int_data[1]), .accum_inter_data_2(int_data[2])
  );

  // Advance one cycle; at the falling edge score any result transfer and
  // enqueue the model result of any activation transfer.
  task automatic tick();
    exp_t e;
    int sp, sf;
    @(negedge clk);
    if (!rst) begin
      for (int j = 0; j < 3; j++) begin
        if (int_vld[j] && !int_busy[j]) begin
          n_total++;
          if (sbq.size() == 0)
            $display("FAIL sb_inter%0d: got %0d, required no result", j, $signed(int_data[j]));
          else if (int_data[j] !== sbq[0].p[j])
            $display("FAIL sb_inter%0d: got %0d, required %0d", j, $signed(int_data[j]), $signed(sbq[0].p[j]));
          else n_pass++;
          got_p[j] = 1'b1;
        end
        if (out_vld[j] && !out_busy[j]) begin
          n_total++;
          if (sbq.size() == 0)
            $display("FAIL sb_out%0d: got %0d, required no result", j, $signed(out_data[j]));
          else if (out_data[j] !== sbq[0].f[j])
            $display("FAIL sb_out%0d: got %0d, required %0d", j, $signed(out_data[j]), $signed(sbq[0].f[j]));
          else n_pass++;
          got_f[j] = 1'b1;
        end
      end
      if (&got_p && &got_f) begin
        if (sbq.size() > 0) void'(sbq.pop_front());
        got_p = '0;
        got_f = '0;
      end
      if ((&{aiv_vld, ait_vld}) && !(|{aiv_busy, ait_busy})) begin
        for (int j = 0; j < 3; j++) begin
          sp = 0;
          for (int i = 0; i < 3; i++) sp += int'($signed(aiv_data[i])) * wm[i][j];
          sf = sp;
          for (int i = 0; i < 3; i++) sf += int'($signed(ait_data[i])) * wm[3+i][j];
          e.p[j] = sp;
          e.f[j] = sf;
        end
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Stream three tokens into all six weight channels; m = main rows, cs = cascade rows.
  task automatic load_weights(input int m[3][3], input int cs[3][3], input string nm);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        wiv_data[j] = 8'(m[k][j]);
        wit_data[j] = 8'(cs[k][j]);
      end
      wiv_vld = 3'b111;
      wit_vld = 3'b111;
      n_total++;
      if ({wiv_busy, wit_busy} !== 6'b0)
        $display("FAIL %s_wbusy_tok%0d: busy=%b, required 000000", nm, k, {wiv_busy, wit_busy});
      else n_pass++;
      tick();
    end
    wiv_vld = '0;
    wit_vld = '0;
    n_total++;
    if ({wiv_busy, wit_busy} !== 6'b111111)
      $display("FAIL %s_wbusy_full: busy=%b, required 111111", nm, {wiv_busy, wit_busy});
    else n_pass++;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) begin
        wm[k][j]   = m[k][j];
        wm[3+k][j] = cs[k][j];
      end
  endtask

  // Offer a full activation vector and return just after it is consumed.
  task automatic send_vec(input int a0, a1, a2, c0, c1, c2, input string nm);
    int n;
    aiv_data[0] = 8'(a0); aiv_data[1] = 8'(a1); aiv_data[2] = 8'(a2);
    ait_data[0] = 8'(c0); ait_data[1] = 8'(c1); ait_data[2] = 8'(c2);
    aiv_vld = 3'b111;
    ait_vld = 3'b111;
    n = 0;
    while ((|{aiv_busy, ait_busy}) && n < 40) begin
      tick();
      n++;
    end
    n_total++;
    if (|{aiv_busy, ait_busy})
      $display("FAIL %s_accept: act busy=%b, required 000000 within 40 cycles", nm, {aiv_busy, ait_busy});
    else n_pass++;
    tick();
    aiv_vld = '0;
    ait_vld = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wiv_vld = '0; wit_vld = '0; aiv_vld = '0; ait_vld = '0;
    out_busy = '0; int_busy = '0;
    for (int j = 0; j < 3; j++) begin
      wiv_data[j] = '0; wit_data[j] = '0; aiv_data[j] = 8'd5; ait_data[j] = 8'd5;
    end
    got_p = '0; got_f = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({wiv_busy, wit_busy, aiv_busy, ait_busy} !== 12'hFFF)
      $display("FAIL rst_busy: busy=%h, required fff", {wiv_busy, wit_busy, aiv_busy, ait_busy});
    else n_pass++;
    n_total++;
    if ({int_vld, out_vld} !== 6'b0 || {int_data[0], int_data[1], int_data[2]} !== 96'b0 ||
        {out_data[0], out_data[1], out_data[2]} !== 96'b0)
      $display("FAIL rst_outputs: vld=%b, required 000000 with all data 0", {int_vld, out_vld});
    else n_pass++;
    aiv_vld = 3'b111;
    ait_vld = 3'b111;
    rst = 1'b0;
    #1;
    n_total++;
    if ({wiv_busy, wit_busy} !== 6'b0 || {aiv_busy, ait_busy} !== 6'b111111)
      $display("FAIL rst_release: wbusy=%b abusy=%b, required 000000/111111",
               {wiv_busy, wit_busy}, {aiv_busy, ait_busy});
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if ({aiv_busy, ait_busy} !== 6'b111111 || {int_vld, out_vld} !== 6'b0)
        $display("FAIL idle_act_blocked%0d: abusy=%b vld=%b, required 111111/000000",
                 c, {aiv_busy, ait_busy}, {int_vld, out_vld});
      else n_pass++;
    end
    aiv_vld = '0;
    ait_vld = '0;
  endtask

  task automatic test_basic();
    int m[3][3] = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
    int cs[3][3] = '{'{2, 2, 2}, '{2, 2, 2}, '{2, 2, 2}};
    load_weights(m, cs, "basic");
    send_vec(1, 2, 3, 1, 1, 1, "basic");
    for (int j = 0; j < 3; j++) begin
      n_total++;
      if (int_vld[j] !== 1'b1 || int_data[j] !== 32'd6)
        $display("FAIL basic_inter%0d: vld=%b data=%0d, required 1/6", j, int_vld[j], $signed(int_data[j]));
      else n_pass++;
      n_total++;
      if (out_vld[j] !== 1'b1 || out_data[j] !== 32'd12)
        $display("FAIL basic_out%0d: vld=%b data=%0d, required 1/12", j, out_vld[j], $signed(out_data[j]));
      else n_pass++;
    end
    n_total++;
    if ({aiv_busy, ait_busy} !== 6'b111111)
      $display("FAIL basic_pending_busy: abusy=%b, required 111111", {aiv_busy, ait_busy});
    else n_pass++;
    tick();
    n_total++;
    if ({int_vld, out_vld} !== 6'b0)
      $display("FAIL basic_drain: vld=%b, required 000000", {int_vld, out_vld});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    out_busy[1] = 1'b1;
    send_vec(2, 0, -1, 3, 0, 0, "bp");
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++;
      if (out_vld[1] !== 1'b1 || out_data[1] !== 32'd7)
        $display("FAIL bp_hold%0d: vld=%b data=%0d, required 1/7", c, out_vld[1], $signed(out_data[1]));
      else n_pass++;
      n_total++;
      if ({int_vld, out_vld[2], out_vld[0]} !== 5'b0 || {aiv_busy, ait_busy} !== 6'b111111)
        $display("FAIL bp_others%0d: vld=%b abusy=%b, required 00000/111111",
                 c, {int_vld, out_vld[2], out_vld[0]}, {aiv_busy, ait_busy});
      else n_pass++;
    end
    out_busy[1] = 1'b0;
    tick();
    n_total++;
    if (out_vld !== 3'b0)
      $display("FAIL bp_release: out vld=%b, required 000", out_vld);
    else n_pass++;
  endtask

  task automatic test_partial();
    aiv_data = '{8'd1, 8'd1, 8'd1};
    ait_data = '{8'd1, 8'd1, 8'd1};
    aiv_vld = 3'b111;
    ait_vld = 3'b011;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if ({int_vld, out_vld} !== 6'b0 || {aiv_busy, ait_busy} !== 6'b0)
        $display("FAIL partial_hold%0d: vld=%b abusy=%b, required 000000/000000",
                 c, {int_vld, out_vld}, {aiv_busy, ait_busy});
      else n_pass++;
    end
    ait_vld = 3'b111;
    tick();
    aiv_vld = '0;
    ait_vld = '0;
    n_total++;
    if ({int_vld, out_vld} !== 6'b111111 || int_data[2] !== 32'd3 || out_data[2] !== 32'd9)
      $display("FAIL partial_consume: vld=%b inter2=%0d out2=%0d, required 111111/3/9",
               {int_vld, out_vld}, $signed(int_data[2]), $signed(out_data[2]));
    else n_pass++;
    n_total++;
    if ({wiv_busy, wit_busy} !== 6'b111111)
      $display("FAIL last_vec_wbusy: busy=%b, required 111111", {wiv_busy, wit_busy});
    else n_pass++;
    tick();
    n_total++;
    if ({wiv_busy, wit_busy} !== 6'b0 || {aiv_busy, ait_busy} !== 6'b111111)
      $display("FAIL release_after_set: wbusy=%b abusy=%b, required 000000/111111",
               {wiv_busy, wit_busy}, {aiv_busy, ait_busy});
    else n_pass++;
  endtask

  task automatic test_signed();
    int m[3][3] = '{'{-128, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    int cs[3][3] = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    load_weights(m, cs, "signed");
    send_vec(-128, 0, 0, 0, 0, 0, "sgn_neg");
    n_total++;
    if (int_data[0] !== 32'd16384 || out_data[0] !== 32'd16384 || int_data[1] !== 32'd0)
      $display("FAIL signed_neg: inter0=%0d out0=%0d inter1=%0d, required 16384/16384/0",
               $signed(int_data[0]), $signed(out_data[0]), $signed(int_data[1]));
    else n_pass++;
    tick();
    send_vec(127, 0, 0, 0, 0, 0, "sgn_pos");
    n_total++;
    if (int_data[0] !== 32'hFFFFC080 || out_data[0] !== 32'hFFFFC080)
      $display("FAIL signed_pos: inter0=%h out0=%h, required ffffc080/ffffc080", int_data[0], out_data[0]);
    else n_pass++;
    tick();
    send_vec(5, 5, 5, 5, 5, 5, "sgn_third");
    tick();
    n_total++;
    if ({wiv_busy, wit_busy} !== 6'b0)
      $display("FAIL signed_release: wbusy=%b, required 000000", {wiv_busy, wit_busy});
    else n_pass++;
  endtask

  task automatic test_reload();
    int m[3][3] = '{'{3, 1, 1}, '{0, 1, 1}, '{0, 1, 1}};
    int cs[3][3] = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
    load_weights(m, cs, "reload");
    wiv_data[0] = 8'd99;
    wiv_vld[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      n_total++;
      if (wiv_busy[0] !== 1'b1)
        $display("FAIL reload_no_overwrite%0d: busy=%b, required 1", c, wiv_busy[0]);
      else n_pass++;
      tick();
    end
    wiv_vld[0] = 1'b0;
    send_vec(4, 0, 0, 0, 0, 0, "reload");
    n_total++;
    if (int_data[0] !== 32'd12 || int_data[1] !== 32'd4 || out_data[0] !== 32'd12)
      $display("FAIL reload_result: inter0=%0d inter1=%0d out0=%0d, required 12/4/12",
               $signed(int_data[0]), $signed(int_data[1]), $signed(out_data[0]));
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (sbq.size() != 0)
      $display("FAIL sb_empty: %0d results outstanding, required 0", sbq.size());
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    out_busy = 3'b111;
    int_busy = 3'b111;
    send_vec(1, 1, 1, 1, 1, 1, "abort");
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({int_vld, out_vld} !== 6'b0 || out_data[0] !== 32'd0 || {aiv_busy, wiv_busy} !== 6'b111111)
      $display("FAIL abort_reset: vld=%b out0=%0d busy=%b, required 000000/0/111111",
               {int_vld, out_vld}, $signed(out_data[0]), {aiv_busy, wiv_busy});
    else n_pass++;
    sbq.delete();
    got_p = '0;
    got_f = '0;
    out_busy = '0;
    int_busy = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_total++;
    if ({wiv_busy, wit_busy} !== 6'b0 || {aiv_busy, ait_busy} !== 6'b111111)
      $display("FAIL abort_release: wbusy=%b abusy=%b, required 000000/111111",
               {wiv_busy, wit_busy}, {aiv_busy, ait_busy});
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_partial();
    test_signed();
    test_reload();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
